// File: rtl/voltage_sequencer.sv
// Power-board voltage sequencer: ramps the 3-bit mux one code per dwell toward the
// requested target, then supervises power-good and latches a fault on timeout or loss.
`timescale 1ns/1ps
module voltage_sequencer #(
  parameter int STEP_CYCLES = 50000,
  parameter int PG_TIMEOUT  = 500000
) (
  input  logic       CLOCK_50,
  input  logic       RESET,
  input  logic       enable,
  input  logic [2:0] target_sel,
  input  logic       power_good,
  input  logic       fault_clear,
  output logic       power_en,
  output logic [2:0] voltage_mux,
  output logic       busy,
  output logic       fault,
  output logic [1:0] fault_code
);

  localparam int MAX_CYCLES = (STEP_CYCLES > PG_TIMEOUT) ? STEP_CYCLES : PG_TIMEOUT;
  localparam int TW = $clog2(MAX_CYCLES) + 1;
  localparam logic [TW-1:0] STEP_RELOAD = TW'(STEP_CYCLES - 1);
  localparam logic [TW-1:0] PG_RELOAD   = TW'(PG_TIMEOUT - 1);

  typedef enum logic [2:0] {OFF, SETTLE, VERIFY, RUN, FAULT} state_t;

  logic [1:0]    enSync_q;
  logic [1:0]    pgSync_q;
  logic [2:0]    tgtSync1_q;
  logic [2:0]    tgtSync2_q;
  logic          enS;
  logic          pgS;
  logic [2:0]    tgtS;

  state_t        state_q;
  logic [TW-1:0] timer_q;
  logic          powerEn_q;
  logic [2:0]    mux_q;
  logic          busy_q;
  logic          fault_q;
  logic [1:0]    faultCode_q;
  logic [2:0]    stepCode;

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      enSync_q   <= '0;
      pgSync_q   <= '0;
      tgtSync1_q <= '0;
      tgtSync2_q <= '0;
    end else begin
      enSync_q   <= {enSync_q[0], enable};
      pgSync_q   <= {pgSync_q[0], power_good};
      tgtSync1_q <= target_sel;
      tgtSync2_q <= tgtSync1_q;
    end
  end

  assign enS  = enSync_q[1];
  assign pgS  = pgSync_q[1];
  assign tgtS = tgtSync2_q;

  // One code toward the target; only used when the mux is not already there.
  assign stepCode = (tgtS > mux_q) ? mux_q + 3'd1 : mux_q - 3'd1;

  // Kill (en_s low) is tested first in every powered state so it beats step,
  // verify and fault detection in the same cycle.
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      state_q     <= OFF;
      timer_q     <= '0;
      powerEn_q   <= 1'b0;
      mux_q       <= 3'd0;
      busy_q      <= 1'b0;
      fault_q     <= 1'b0;
      faultCode_q <= 2'b00;
    end else begin
      case (state_q)
        OFF: begin
          if (enS) begin
            state_q   <= SETTLE;
            powerEn_q <= 1'b1;
            busy_q    <= 1'b1;
            mux_q     <= 3'd0;
            timer_q   <= STEP_RELOAD;
          end
        end
        SETTLE: begin
          if (!enS) begin
            state_q   <= OFF;
            powerEn_q <= 1'b0;
            mux_q     <= 3'd0;
            busy_q    <= 1'b0;
            timer_q   <= '0;
          end else if (timer_q == '0) begin
            if (mux_q == tgtS) begin
              state_q <= VERIFY;
              timer_q <= PG_RELOAD;
            end else begin
              mux_q   <= stepCode;
              timer_q <= STEP_RELOAD;
            end
          end else begin
            timer_q <= timer_q - TW'(1);
          end
        end
        VERIFY: begin
          if (!enS) begin
            state_q   <= OFF;
            powerEn_q <= 1'b0;
            mux_q     <= 3'd0;
            busy_q    <= 1'b0;
            timer_q   <= '0;
          end else if (pgS) begin
            state_q <= RUN;
            busy_q  <= 1'b0;
          end else if (timer_q == '0) begin
            state_q     <= FAULT;
            powerEn_q   <= 1'b0;
            mux_q       <= 3'd0;
            busy_q      <= 1'b0;
            fault_q     <= 1'b1;
            faultCode_q <= 2'b01;
          end else begin
            timer_q <= timer_q - TW'(1);
          end
        end
        RUN: begin
          if (!enS) begin
            state_q   <= OFF;
            powerEn_q <= 1'b0;
            mux_q     <= 3'd0;
            timer_q   <= '0;
          end else if (!pgS) begin
            state_q     <= FAULT;
            powerEn_q   <= 1'b0;
            mux_q       <= 3'd0;
            fault_q     <= 1'b1;
            faultCode_q <= 2'b10;
          end else if (tgtS != mux_q) begin
            state_q <= SETTLE;
            busy_q  <= 1'b1;
            timer_q <= STEP_RELOAD;
          end
        end
        FAULT: begin
          // Leaving needs both the acknowledge and the request withdrawn.
          if (fault_clear && !enS) begin
            state_q     <= OFF;
            fault_q     <= 1'b0;
            faultCode_q <= 2'b00;
            timer_q     <= '0;
          end
        end
        default: begin
          state_q   <= OFF;
          powerEn_q <= 1'b0;
          mux_q     <= 3'd0;
          busy_q    <= 1'b0;
          fault_q   <= 1'b0;
        end
      endcase
    end
  end

  assign power_en    = powerEn_q;
  assign voltage_mux = mux_q;
  assign busy        = busy_q;
  assign fault       = fault_q;
  assign fault_code  = faultCode_q;

endmodule

// File: doc/voltage_sequencer.md
# voltage_sequencer

- Sequences the power board's 3-bit voltage-select mux and its enable (kill) line.
- Ramps the mux code one step at a time toward a requested target, with a fixed dwell per step.
- Checks the board's power-good feedback once the target is reached, and latches a fault if power-good is missing or lost.
- Sits between the user controls (switches/host) and the GPIO pins that drive the mux, enable and power-good signals.

## Interface

Parameters:
- STEP_CYCLES, default 50000 (1 ms at 50 MHz): dwell cycles per mux code. Must be ≥1.
- PG_TIMEOUT, default 500000 (10 ms): cycles allowed for power-good after reaching the target. Must be ≥1.

Ports:
- CLOCK_50  input  1  system clock, 50 MHz.
- RESET  input  1  asynchronous reset, active high.
- enable  input  1  power request (kill switch); asynchronous, synchronized internally.
- target_sel  input  3  requested mux code; asynchronous, synchronized internally.
- power_good  input  1  power-good feedback from the board; asynchronous, synchronized internally.
- fault_clear  input  1  fault acknowledge; synchronous to CLOCK_50.
- power_en  output  1  drives the board enable/kill pin; 1 = powered.
- voltage_mux  output  3  drives the mux select pins.
- busy  output  1  high in SETTLE and VERIFY.
- fault  output  1  high in FAULT.
- fault_code  output  2  00 none, 01 power-good timeout, 10 power-good lost.

## Operation

- **Synchronizers.** enable, power_good and each target_sel bit pass through 2-flop synchronizers. The FSM uses only the synchronized values (en_s, pg_s, tgt_s).
- **Timer.** One down-counter, width $clog2(max(STEP_CYCLES, PG_TIMEOUT)) + 1.
- **States.** OFF, SETTLE, VERIFY, RUN, FAULT.
- **OFF**
  - Outputs: power_en=0, voltage_mux=0.
  - en_s=1 → SETTLE: power_en=1, timer=STEP_CYCLES-1.
- **SETTLE**
  - Timer decrements each cycle.
  - On the cycle timer==0:
    - if voltage_mux==tgt_s → VERIFY, timer=PG_TIMEOUT-1;
    - else voltage_mux steps ±1 toward tgt_s (never jumps more than one code), timer reloads STEP_CYCLES-1, state stays SETTLE.
  - Changes to tgt_s mid-ramp take effect at the next step decision.
- **VERIFY**
  - pg_s=1 → RUN.
  - Otherwise the timer decrements. On the cycle timer==0 with pg_s=0 → FAULT, fault_code=01.
- **RUN**
  - tgt_s != voltage_mux → SETTLE, timer=STEP_CYCLES-1. The first step occurs after a full dwell.
  - pg_s=0 → FAULT, fault_code=10. Evaluated before the retarget check.
- **FAULT**
  - Outputs: power_en=0, voltage_mux=0, fault=1; fault_code held.
  - Exit to OFF only when fault_clear=1 and en_s=0 in the same cycle; fault_code returns to 00.
  - fault_clear while en_s=1 is ignored.
- **Kill priority.** en_s=0 in SETTLE, VERIFY or RUN → OFF on the next edge, with power_en=0 and voltage_mux=0 at that edge. Kill overrides step, verify and fault detection in the same cycle. In FAULT, en_s=0 alone does not exit.
- **Power-up start.** Each power-up begins at mux code 0.
- **Code range.** voltage_mux stays within 0..7; no wrap.

## Timing

- **Reset values.** RESET asserted forces state OFF, power_en=0, voltage_mux=0, busy=0, fault=0, fault_code=00, timer=0, synchronizers=0. Effect is immediate (asynchronous), including mid-ramp.
- **Input latency.** An input edge is visible to the FSM 2 edges later; the resulting output changes at the 3rd edge.
- **Step timing.** Each mux code is held exactly STEP_CYCLES cycles before the next step or before entering VERIFY.
- **Power-good timeout.** VERIFY lasts at most PG_TIMEOUT cycles; FAULT is entered on the edge after the last VERIFY cycle.
- **Output registers.** All outputs are registered; no combinational path from input to output.
- **busy.** busy=1 exactly while the state is SETTLE or VERIFY.

## Test plan

Bench parameters: STEP_CYCLES=4, PG_TIMEOUT=8. Edge numbers count from the edge on which enable rises (edge 0).

- **Reset.** Assert RESET mid-ramp (voltage_mux=2) → all outputs 0 immediately. After release, the block stays in OFF.
- **Power-up ramp.** target_sel=3, power_good=1, enable rises at edge 0 → required response:
  - power_en=1 at edge 3;
  - voltage_mux=1 at edge 7, 2 at edge 11, 3 at edge 15;
  - VERIFY at edge 19, RUN at edge 20, with busy low from edge 20.
- **Power-good timeout.** Same stimulus with power_good=0 → FAULT at edge 27, fault_code=01, power_en=0, voltage_mux=0.
- **Down-ramp.** In RUN at code 3, target_sel→1 → voltage_mux=2 at +7 edges and 1 at +11, then VERIFY and RUN. No code skipped.
- **Kill mid-ramp.** Drop enable while voltage_mux=1 → power_en=0 and voltage_mux=0 at +3 edges, state OFF, no fault.
- **Power-good lost.** In RUN, drop power_good → FAULT at +3 edges, fault_code=10. Then:
  - fault_clear with enable=1 → stays in FAULT;
  - enable=0 plus fault_clear → OFF, fault=0, fault_code=00.
